dsram_port_arbiter: RTL and testbench

Serializes the two memory-stage data-SRAM requests of the dual-issue pipeline (master pipe = port 0, slave pipe = port 1) onto the single shared data bus, which uses a request / address-accepted / data-returned handshake. Each port's inputs are the per-pipe data-SRAM request signals produced by the memory-access stage; exception masking has already been applied. The block holds the pipeline via a stall output until every enabled request has completed. It then returns the captured read data for each port and gives port 0 strict program-order priority.

---
 rtl/dsram_port_arbiter_pkg.sv | 18 +
 rtl/dsram_port_arbiter_wstrb_to_size.sv | 18 +
 rtl/dsram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dsram_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_port_arbiter_pkg.sv
// Shared types for the data-SRAM port arbiter and bus bridges.
package dsram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned WSTRB_W = 4;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

endpackage

// File: rtl/dsram_port_arbiter_wstrb_to_size.sv
// Byte-strobe to transfer-size decoder; shared with the instruction-side bridge.
module wstrb_to_size
    import dsram_port_arbiter_pkg::*;
(
    input  logic [WSTRB_W-1:0] wstrb,
    output logic [SIZE_W-1:0]  size_c
);

    always_comb begin
        size_c = SZ_B;
        case (wstrb)
            4'b1111:          size_c = SZ_W;
            4'b0011, 4'b1100: size_c = SZ_H;
            default:          size_c = SZ_B;
        endcase
    end

endmodule

// File: rtl/dsram_port_arbiter.sv
// Serializes the two memory-stage data-SRAM requests onto one shared bus,
// port 0 first, stalling the pipeline until every enabled port has completed.
module dsram_port_arbiter
    import dsram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_en,
    input  logic [3:0]        p0_wen,
    input  logic [1:0]        p0_rlen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_en,
    input  logic [3:0]        p1_wen,
    input  logic [1:0]        p1_rlen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              flush,
    input  logic              hold,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t state_q, state_d;
    logic              sel_q, sel_d;
    logic [1:0]        done_q, done_d;
    logic              drop_q, drop_d;
    logic              bus_wr_q, bus_wr_d;
    logic [SIZE_W-1:0] bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              load_c;

    logic [1:0]        pend_c;
    logic              first_c, other_c, issue_port_c, drop_eff_c;
    logic [3:0]        iss_wen_c;
    logic [1:0]        iss_rlen_c;
    logic [SIZE_W-1:0] iss_wsize_c;
    logic [ADDR_W-1:0] iss_addr_c;
    logic [DATA_W-1:0] iss_wdata_c;

    assign pend_c       = {p1_en & ~done_q[1], p0_en & ~done_q[0]};
    assign first_c      = ~pend_c[0];
    assign other_c      = ~sel_q;
    assign drop_eff_c   = drop_q | flush;
    assign issue_port_c = (state_q == IDLE) ? first_c : other_c;

    // Fields of the port about to be placed on the bus
    always_comb begin
        if (issue_port_c) begin
            iss_wen_c   = p1_wen;
            iss_rlen_c  = p1_rlen;
            iss_addr_c  = p1_addr;
            iss_wdata_c = p1_wdata;
        end else begin
            iss_wen_c   = p0_wen;
            iss_rlen_c  = p0_rlen;
            iss_addr_c  = p0_addr;
            iss_wdata_c = p0_wdata;
        end
    end

    wstrb_to_size u_wsize (
        .wstrb  (iss_wen_c),
        .size_c (iss_wsize_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!flush && (|pend_c)) state_d = ADDR;
            ADDR: begin
                if (bus_addr_ok)  state_d = DATA;
                else if (flush)   state_d = IDLE;
            end
            DATA: begin
                if (bus_data_ok) begin
                    if (drop_eff_c)            state_d = IDLE;
                    else if (pend_c[other_c])  state_d = ADDR;
                    else                       state_d = DONE;
                end
            end
            DONE: if (flush || !hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are latched at issue so they cannot move while awaiting accept
    always_comb begin
        sel_d       = sel_q;
        done_d      = done_q;
        drop_d      = drop_q;
        bus_wr_d    = bus_wr_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        load_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    done_d = 2'b00;
                end else if (|pend_c) begin
                    sel_d  = first_c;
                    load_c = 1'b1;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    if (flush) drop_d = 1'b1;
                end else if (flush) begin
                    done_d = 2'b00;
                end
            end
            DATA: begin
                if (flush) drop_d = 1'b1;
                if (bus_data_ok) begin
                    if (drop_eff_c) begin
                        drop_d = 1'b0;
                        done_d = 2'b00;
                    end else begin
                        done_d[sel_q] = 1'b1;
                        if (sel_q) p1_rdata_d = bus_rdata;
                        else       p0_rdata_d = bus_rdata;
                        if (pend_c[other_c]) begin
                            sel_d  = other_c;
                            load_c = 1'b1;
                        end
                    end
                end
            end
            DONE: if (flush || !hold) done_d = 2'b00;
            default: ;
        endcase
        if (load_c) begin
            bus_wr_d    = |iss_wen_c;
            bus_size_d  = (|iss_wen_c) ? iss_wsize_c : iss_rlen_c;
            bus_addr_d  = iss_addr_c;
            bus_wstrb_d = iss_wen_c;
            bus_wdata_d = iss_wdata_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            done_q      <= 2'b00;
            drop_q      <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= SZ_B;
            bus_addr_q  <= '0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            bus_wr_q    <= bus_wr_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign bus_req   = (state_q == ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    // Stall is combinational so a flush releases the pipeline in the same cycle
    assign mem_stall = !rst && (state_q != DONE) && (|pend_c) && !flush
                       && !((state_q == DATA) && drop_q);

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Bench for dsram_port_arbiter: directed scenarios plus randomized pipeline/bus traffic
// checked every cycle against a transaction-level reference model.
module tb_dsram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_en, p1_en;
    logic [3:0]  p0_wen, p1_wen;
    logic [1:0]  p0_rlen, p1_rlen;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        flush, hold, mem_stall;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;

    always #5 clk = ~clk;

    dsram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_en(p0_en), .p0_wen(p0_wen), .p0_rlen(p0_rlen), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
        .p1_en(p1_en), .p1_wen(p1_wen), .p1_rlen(p1_rlen), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
        .flush(flush), .hold(hold), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    int errors = 0;
    int checks = 0;

    // reference model: which port owns the bus and what it must show
    logic [31:0] m_rdata [2];
    bit          m_done  [2];
    int          m_cur = -1;
    bit          m_acc, m_drop, m_fin;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wen;
    logic [1:0]  m_rlen;

    // bus responder and observation
    bit          rand_mode = 0;
    bit          s_req, s_stall, outst, adv = 1;
    int          req_age, acc_lat = 0, dat_lat = 1, dcnt;
    logic [31:0] next_rdata = 32'h0;
    int          acc_cnt = 0, req_cnt = 0;
    logic [31:0] log_addr  [$];
    logic [1:0]  log_size  [$];
    logic [3:0]  log_wstrb [$];
    bit          log_wr    [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(int p);
        if (p == 0) return p0_en && !m_done[0];
        return p1_en && !m_done[1];
    endfunction

    // size from the number of strobed bytes, or the read length
    function automatic logic [1:0] exp_size(logic [3:0] wen, logic [1:0] rlen);
        case ($countones(wen))
            0:       return rlen;
            4:       return 2'd2;
            2:       return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_issue(int p);
        m_cur = p;
        m_acc = 0;
        if (p == 0) begin m_addr = p0_addr; m_wdata = p0_wdata; m_wen = p0_wen; m_rlen = p0_rlen; end
        else        begin m_addr = p1_addr; m_wdata = p1_wdata; m_wen = p1_wen; m_rlen = p1_rlen; end
    endtask

    task automatic model_step();
        bit dropping;
        if (rst) begin
            m_rdata[0] = 0; m_rdata[1] = 0; m_done[0] = 0; m_done[1] = 0;
            m_cur = -1; m_acc = 0; m_drop = 0; m_fin = 0;
            return;
        end
        if (m_fin) begin
            if (flush || !hold) begin m_fin = 0; m_done[0] = 0; m_done[1] = 0; end
        end else if (m_cur < 0) begin
            if (flush) begin m_done[0] = 0; m_done[1] = 0; end
            else if (pending(0)) model_issue(0);
            else if (pending(1)) model_issue(1);
        end else if (!m_acc) begin
            if (bus_addr_ok) begin m_acc = 1; if (flush) m_drop = 1; end
            else if (flush) begin m_cur = -1; m_done[0] = 0; m_done[1] = 0; end
        end else begin
            dropping = m_drop || flush;
            if (flush) m_drop = 1;
            if (bus_data_ok) begin
                if (dropping) begin
                    m_cur = -1; m_drop = 0; m_done[0] = 0; m_done[1] = 0;
                end else begin
                    m_rdata[m_cur] = bus_rdata;
                    m_done[m_cur]  = 1;
                    if (pending(1 - m_cur)) model_issue(1 - m_cur);
                    else begin m_cur = -1; m_fin = 1; end
                end
            end
        end
    endtask

    task automatic bus_drive();
        bus_addr_ok = bus_req && (req_age >= acc_lat);
        bus_data_ok = outst && (dcnt == 0);
        if (rand_mode && !outst && !bus_addr_ok && ($urandom % 10 == 0)) bus_data_ok = 1;
        if (bus_data_ok) bus_rdata = rand_mode ? $urandom : next_rdata;
        else             bus_rdata = 32'h0;
    endtask

    task automatic bus_update();
        if (rst) begin outst = 0; req_age = 0; return; end
        if (outst) begin
            if (bus_data_ok) outst = 0;
            else             dcnt--;
        end
        if (s_req && bus_addr_ok) begin
            outst   = 1;
            dcnt    = dat_lat - 1;
            req_age = 0;
            if (rand_mode) begin acc_lat = $urandom_range(0, 3); dat_lat = $urandom_range(1, 4); end
        end else if (s_req) req_age++;
        else                req_age = 0;
    endtask

    task automatic compare();
        bit exp_req, exp_stall;
        exp_req   = (m_cur >= 0) && !m_acc;
        exp_stall = !rst && !m_fin && (pending(0) || pending(1)) && !flush && !m_drop;
        check("bus_req", 32'(bus_req), 32'(exp_req));
        check("mem_stall", 32'(mem_stall), 32'(exp_stall));
        check("p0_rdata", p0_rdata, m_rdata[0]);
        check("p1_rdata", p1_rdata, m_rdata[1]);
        if (exp_req) begin
            check("bus_wr", 32'(bus_wr), 32'(m_wen != 4'b0000));
            check("bus_size", 32'(bus_size), 32'(exp_size(m_wen, m_rlen)));
            check("bus_addr", bus_addr, m_addr);
            check("bus_wstrb", 32'(bus_wstrb), 32'(m_wen));
            check("bus_wdata", bus_wdata, m_wdata);
        end
        s_req   = bus_req;
        s_stall = mem_stall;
        adv     = (!exp_stall && !hold) || flush;
        if (bus_req) req_cnt++;
        if (bus_req && bus_addr_ok) begin
            acc_cnt++;
            log_addr.push_back(bus_addr);
            log_size.push_back(bus_size);
            log_wstrb.push_back(bus_wstrb);
            log_wr.push_back(bus_wr);
        end
    endtask

    task automatic tick();
        bus_drive();
        #1;
        compare();
        @(posedge clk);
        model_step();
        bus_update();
        @(negedge clk);
    endtask

    task automatic run_instr(int max, output int stalls);
        bit fin;
        fin = 0;
        stalls = 0;
        for (int i = 0; i < max && !fin; i++) begin
            tick();
            if (s_stall) stalls++;
            else         fin = 1;
        end
        check("instr_complete", 32'(fin), 32'd1);
    endtask

    task automatic new_instr();
        p0_en = ($urandom % 5) < 3;
        p1_en = ($urandom % 5) < 3;
        for (int p = 0; p < 2; p++) begin
            logic [3:0] w;
            case ($urandom % 14)
                0: w = 4'b0001; 1: w = 4'b0010; 2: w = 4'b0100; 3: w = 4'b1000;
                4: w = 4'b0011; 5: w = 4'b1100; 6: w = 4'b1111;
                default: w = 4'b0000;
            endcase
            if (p == 0) begin
                p0_wen = w; p0_rlen = 2'($urandom_range(0, 2)); p0_addr = $urandom; p0_wdata = $urandom;
            end else begin
                p1_wen = w; p1_rlen = 2'($urandom_range(0, 2)); p1_addr = $urandom; p1_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, st2, a0, r0, n0, h_st;
        rst = 1; flush = 0; hold = 0;
        p0_en = 0; p0_wen = 0; p0_rlen = 0; p0_addr = 0; p0_wdata = 0;
        p1_en = 0; p1_wen = 0; p1_rlen = 0; p1_addr = 0; p1_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        @(posedge clk); model_step(); bus_update(); @(negedge clk);
        tick();
        rst = 0;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);

        // single read, zero-wait bus
        p0_en = 1; p0_wen = 4'b0000; p0_rlen = 2; p0_addr = 32'h1000_0004;
        next_rdata = 32'hDEAD_BEEF; a0 = acc_cnt; n0 = log_size.size();
        run_instr(10, st);
        p0_en = 0;
        check("t1_stalls", 32'(st), 32'd3);
        check("t1_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        if (log_size.size() > n0) begin
            check("t1_size", 32'(log_size[n0]), 32'd2);
            check("t1_wr", 32'(log_wr[n0]), 32'd0);
        end

        // both ports: halfword store then byte read
        p0_en = 1; p0_wen = 4'b1100; p0_addr = 32'h2002; p0_wdata = 32'hAABB_AABB;
        p1_en = 1; p1_wen = 4'b0000; p1_rlen = 0; p1_addr = 32'h3001;
        next_rdata = 32'h0000_005A; a0 = acc_cnt; n0 = log_size.size();
        run_instr(20, st);
        p0_en = 0; p1_en = 0;
        check("t2_stalls", 32'(st), 32'd5);
        check("t2_accepts", 32'(acc_cnt - a0), 32'd2);
        check("t2_p1_rdata", p1_rdata, 32'h0000_005A);
        if (log_size.size() > n0 + 1) begin
            check("t2_first_addr", log_addr[n0], 32'h2002);
            check("t2_first_size", 32'(log_size[n0]), 32'd1);
            check("t2_first_wstrb", 32'(log_wstrb[n0]), 32'b1100);
            check("t2_first_wr", 32'(log_wr[n0]), 32'd1);
            check("t2_second_addr", log_addr[n0 + 1], 32'h3001);
            check("t2_second_size", 32'(log_size[n0 + 1]), 32'd0);
        end

        // accept delayed by three cycles
        acc_lat = 3;
        p0_en = 1; p0_wen = 4'b0000; p0_rlen = 1; p0_addr = 32'h4000_0010;
        next_rdata = 32'h1234_5678; a0 = acc_cnt; r0 = req_cnt;
        run_instr(20, st);
        p0_en = 0; acc_lat = 0;
        check("t3_req_cycles", 32'(req_cnt - r0), 32'd4);
        check("t3_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t3_stalls", 32'(st), 32'd6);
        check("t3_rdata", p0_rdata, 32'h1234_5678);

        // flush while port 0 awaits data, port 1 pending
        dat_lat = 3;
        p0_en = 1; p0_wen = 4'b0000; p0_rlen = 2; p0_addr = 32'h5000_0000;
        p1_en = 1; p1_wen = 4'b0000; p1_rlen = 2; p1_addr = 32'h5000_0004;
        next_rdata = 32'hBAD0_BAD0; a0 = acc_cnt;
        for (int i = 0; i < 10 && acc_cnt == a0; i++) tick();
        flush = 1;
        tick();
        flush = 0; p0_en = 0; p1_en = 0;
        for (int i = 0; i < 6; i++) tick();
        dat_lat = 1;
        check("t4_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t4_p0_rdata", p0_rdata, 32'h1234_5678);
        check("t4_p1_rdata", p1_rdata, 32'h0000_005A);
        check("t4_idle_req", 32'(bus_req), 32'd0);
        check("t4_idle_stall", 32'(mem_stall), 32'd0);

        // hold keeps the finished result for two cycles, then releases
        hold = 1;
        p1_en = 1; p1_wen = 4'b0000; p1_rlen = 1; p1_addr = 32'h6000_0002;
        next_rdata = 32'h0000_BEEF; a0 = acc_cnt;
        run_instr(10, st);
        tick(); h_st = int'(s_stall) + int'(s_req);
        hold = 0;
        tick(); h_st += int'(s_stall) + int'(s_req);
        check("t5_stalls", 32'(st), 32'd3);
        check("t5_hold_quiet", 32'(h_st), 32'd0);
        check("t5_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t5_p1_rdata", p1_rdata, 32'h0000_BEEF);
        next_rdata = 32'h0000_C0DE;
        run_instr(10, st2);
        p1_en = 0;
        check("t5_reissue_stalls", 32'(st2), 32'd3);

        // reset while a request waits for accept
        acc_lat = 5;
        p0_en = 1; p0_wen = 4'b0000; p0_rlen = 2; p0_addr = 32'h7000_0000;
        tick();
        check("t6_in_addr", 32'(bus_req), 32'd1);
        rst = 1;
        #1;
        check("t6_stall_in_rst", 32'(mem_stall), 32'd0);
        tick();
        rst = 0; p0_en = 0; acc_lat = 0;
        check("t6_req_after", 32'(bus_req), 32'd0);
        check("t6_p0_rdata", p0_rdata, 32'h0);
        check("t6_p1_rdata", p1_rdata, 32'h0);
        tick();

        // randomized pipeline and bus timing
        rand_mode = 1;
        acc_lat = $urandom_range(0, 3);
        dat_lat = $urandom_range(1, 4);
        adv = 1;
        for (int c = 0; c < 3000; c++) begin
            if (adv) new_instr();
            flush = ($urandom % 16) == 0;
            hold  = ($urandom % 4) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
